mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory port.
// Optional round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          lat_d;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic pick_d;
  logic grant;
  logic in_acc;
  logic in_resp;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // Data loses a tie only if it won the previous grant.
  always_comb begin
    pick_d = d_req & (~if_req | ~last_d);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (grant) begin
      last_d <= pick_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  assign grant   = rst_n & (state == IDLE) & (if_req | d_req);
  assign d_gnt   = grant & pick_d;
  assign if_gnt  = grant & ~pick_d;
  assign in_acc  = (state == ACCESS);
  assign in_resp = (state == RESP);

  assign mem_en    = in_acc;
  assign mem_we    = in_acc & lat_we;
  assign mem_addr  = in_acc ? lat_addr : '0;
  assign mem_wdata = in_acc ? lat_wdata : '0;

  assign if_rvalid = in_resp & ~lat_d;
  assign d_rvalid  = in_resp & lat_d;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state     <= ACCESS;
            cnt       <= '0;
            lat_d     <= pick_d;
            lat_we    <= pick_d & d_we;
            lat_addr  <= pick_d ? d_addr : if_addr;
            lat_wdata <= (pick_d & d_we) ? d_wdata : '0;
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            state <= RESP;
            cnt   <= '0;
            if (lat_d) begin
              d_rdata <= lat_we ? '0 : mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, reset abort,
// arbitration order, RESP-time requests and latency spacing.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  logic          b_zero;
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rd;
  logic          a_ig, a_iv, a_dg, a_dv;
  logic          a_en, a_we, a_busy;
  logic [DW-1:0] a_ird, a_drd, a_wd;
  logic [AW-1:0] a_ma;
  logic          c_ig, c_iv, c_dg, c_dv;
  logic          c_en, c_we, c_busy;
  logic [DW-1:0] c_ird, c_drd, c_wd;
  logic [AW-1:0] c_ma;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MEM_LAT(2), .AW(AW), .DW(DW)) dut (
    .clock(clock), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) u_lat1 (
    .clock(clock), .rst_n(rst_n),
    .if_req(b_zero), .if_addr(b_addr),
    .if_gnt(a_ig), .if_rvalid(a_iv), .if_rdata(a_ird),
    .d_req(b_req), .d_we(b_zero), .d_addr(b_addr),
    .d_wdata(b_rd), .d_gnt(a_dg),
    .d_rvalid(a_dv), .d_rdata(a_drd),
    .mem_en(a_en), .mem_we(a_we),
    .mem_addr(a_ma), .mem_wdata(a_wd),
    .mem_rdata(b_rd), .busy(a_busy)
  );

  mem_port_arbiter #(.MEM_LAT(15), .AW(AW), .DW(DW)) u_lat15 (
    .clock(clock), .rst_n(rst_n),
    .if_req(b_zero), .if_addr(b_addr),
    .if_gnt(c_ig), .if_rvalid(c_iv), .if_rdata(c_ird),
    .d_req(b_req), .d_we(b_zero), .d_addr(b_addr),
    .d_wdata(b_rd), .d_gnt(c_dg),
    .d_rvalid(c_dv), .d_rdata(c_drd),
    .mem_en(c_en), .mem_we(c_we),
    .mem_addr(c_ma), .mem_wdata(c_wd),
    .mem_rdata(b_rd), .busy(c_busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nrv;
    int ng;
    int last_t;
    int f1, s1, f15, s15;

    rst_n     = 1'b0;
    if_req    = 1'b1;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    b_zero    = 1'b0;
    b_req     = 1'b0;
    b_addr    = 32'h80;
    b_rd      = 32'h0F0F0F0F;

    #12;
    chk("rst_ifgnt", if_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_ifrd", if_rdata, 0);
    chk("rst_drd", d_rdata, 0);
    if_req = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    tick();

    // lone fetch
    if_req    = 1'b1;
    if_addr   = 32'h10;
    mem_rdata = 32'h8C010004;
    #1;
    chk("f_gnt", if_gnt, 1);
    chk("f_dgnt", d_gnt, 0);
    chk("f_busy0", busy, 0);
    tick();
    if_req = 1'b0;
    #1;
    chk("f_en1", mem_en, 1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we", mem_we, 0);
    chk("f_busy1", busy, 1);
    chk("f_nogn", if_gnt, 0);
    tick();
    chk("f_en2", mem_en, 1);
    tick();
    chk("f_rv", if_rvalid, 1);
    chk("f_rd", if_rdata, 32'h8C010004);
    chk("f_en3", mem_en, 0);
    chk("f_addr3", mem_addr, 0);
    chk("f_drv", d_rvalid, 0);
    tick();
    chk("f_rv0", if_rvalid, 0);
    chk("f_idle", busy, 0);

    // store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'hDEADBEEF;
    #1;
    chk("s_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    #1;
    chk("s_we1", mem_we, 1);
    chk("s_addr", mem_addr, 32'h20);
    chk("s_wd1", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("s_we2", mem_we, 1);
    chk("s_wd2", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("s_rv", d_rvalid, 1);
    chk("s_rd", d_rdata, 0);
    chk("s_irv", if_rvalid, 0);
    chk("s_we3", mem_we, 0);
    chk("s_wd3", mem_wdata, 0);
    chk("s_ifhold", if_rdata, 32'h8C010004);
    tick();
    chk("s_rv0", d_rvalid, 0);

    // reset in second ACCESS cycle of a load
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h40;
    mem_rdata = 32'h11111111;
    #1;
    chk("r_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    tick();
    chk("r_acc2", mem_en, 1);
    rst_n = 1'b0;
    #1;
    chk("r_en", mem_en, 0);
    chk("r_addr", mem_addr, 0);
    chk("r_busy", busy, 0);
    chk("r_ifrd", if_rdata, 0);
    chk("r_drd", d_rdata, 0);
    tick();
    rst_n = 1'b1;
    nrv = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (d_rvalid) nrv++;
    end
    chk("r_norv", nrv, 0);
    if_req    = 1'b1;
    if_addr   = 32'h44;
    mem_rdata = 32'hA5A50001;
    #1;
    chk("r_next", if_gnt, 1);
    tick();
    if_req = 1'b0;
    tick();
    tick();
    chk("r_nrv", if_rvalid, 1);
    chk("r_nrd", if_rdata, 32'hA5A50001);
    tick();

    // both requesting continuously
    if_req = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    ng     = 0;
    last_t = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      chk("rv_excl", if_rvalid & d_rvalid, 0);
      if (if_gnt || d_gnt) begin
        chk("gnt_one", if_gnt & d_gnt, 0);
        chk($sformatf("arb%0d", ng), d_gnt,
            RR ? ((ng % 2) == 0) : 1'b1);
        if (ng > 0) chk("arb_gap", c - last_t, 4);
        last_t = c;
        ng++;
      end
      tick();
    end
    chk("arb_cnt", ng, 4);
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("arb_idle", busy, 0);

    // request raised during RESP
    d_req     = 1'b1;
    d_addr    = 32'h50;
    mem_rdata = 32'h12345678;
    #1;
    chk("p_dgnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    tick();
    tick();
    if_req  = 1'b1;
    if_addr = 32'h60;
    #1;
    chk("p_wait", if_gnt, 0);
    chk("p_drv", d_rvalid, 1);
    chk("p_drd", d_rdata, 32'h12345678);
    tick();
    chk("p_gnt", if_gnt, 1);
    chk("p_b0", busy, 0);
    tick();
    if_req = 1'b0;
    #1;
    chk("p_b1", busy, 1);
    tick();
    chk("p_b2", busy, 1);
    tick();
    chk("p_b3", busy, 1);
    chk("p_irv", if_rvalid, 1);
    tick();
    chk("p_b4", busy, 0);

    // back-to-back loads at MEM_LAT 1 and 15
    b_req = 1'b1;
    f1 = -1; s1 = -1; f15 = -1; s15 = -1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (a_dv) begin
        if (f1 < 0) f1 = c;
        else if (s1 < 0) s1 = c;
      end
      if (c_dv) begin
        if (f15 < 0) f15 = c;
        else if (s15 < 0) s15 = c;
      end
      tick();
    end
    chk("sp1", s1 - f1, 3);
    chk("sp15", s15 - f15, 17);
    chk("lat15", f15, 16);
    chk("rd15", c_drd, 32'h0F0F0F0F);
    b_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
